// File: rtl/key_switch_input.sv
// Memory-mapped key/switch input block: synchronises and debounces raw buttons and DIP switches,
// latches key presses into write-1-to-clear flags and drives a level interrupt.
module key_switch_input #(
  parameter int NUM_KEYS        = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                clk_in,
  input  logic                sys_rstn,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [31:0]         switch_in,
  input  logic [31:0]         Input_Addr,
  input  logic [3:0]          Input_WE,
  input  logic [31:0]         Input_WriteData,
  output logic [31:0]         Input_ReadData,
  output logic                Input_IRQ
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    REG_SWITCH = 2'd0,
    REG_KEY    = 2'd1,
    REG_EDGE   = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_t;

  // Synchronisers: raw keys idle high (released), switches idle low.
  logic [NUM_KEYS-1:0] key_s1, key_s2;
  logic [31:0]         sw_s1, sw_s2, sw_prev;

  logic [NUM_KEYS-1:0] key_stable, key_stable_nxt;
  logic [CNT_W-1:0]    key_cnt     [NUM_KEYS];
  logic [CNT_W-1:0]    key_cnt_nxt [NUM_KEYS];

  logic [31:0]         sw_stable, sw_stable_nxt;
  logic [CNT_W-1:0]    sw_cnt, sw_cnt_nxt;

  logic [NUM_KEYS-1:0] edge_flags, edge_nxt, edge_clear, key_rise, key_pressed;
  logic                ctrl_en, ctrl_nxt;

  logic [31:0]         byte_mask, clear_full;
  reg_sel_t            reg_sel;
  logic                unused_ok;

  assign reg_sel     = reg_sel_t'(Input_Addr[3:2]);
  assign key_pressed = ~key_s2;

  always_comb begin
    for (int b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{Input_WE[b]}};
  end

  assign clear_full = Input_WriteData & byte_mask;
  assign edge_clear = (reg_sel == REG_EDGE) ? clear_full[NUM_KEYS-1:0] : '0;
  assign ctrl_nxt   = (reg_sel == REG_CTRL && Input_WE[0]) ? Input_WriteData[0] : ctrl_en;
  assign unused_ok  = ^{Input_Addr[31:4], Input_Addr[1:0], clear_full};

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    key_stable_nxt = key_stable;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_cnt_nxt[i] = '0;
      if (key_pressed[i] != key_stable[i]) begin
        if (key_cnt[i] == CNT_LAST) key_stable_nxt[i] = key_pressed[i];
        else                        key_cnt_nxt[i]    = key_cnt[i] + CNT_ONE;
      end
    end
  end

  // Shared switch counter restarts whenever the synchronised word moves again.
  always_comb begin
    sw_stable_nxt = sw_stable;
    sw_cnt_nxt    = '0;
    if (sw_s2 == sw_prev && sw_s2 != sw_stable) begin
      if (sw_cnt == CNT_LAST) sw_stable_nxt = sw_s2;
      else                    sw_cnt_nxt    = sw_cnt + CNT_ONE;
    end
  end

  // A press landing on the same edge as a clear of that bit keeps the flag set.
  assign key_rise = key_stable_nxt & ~key_stable;
  assign edge_nxt = (edge_flags & ~edge_clear) | key_rise;

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      key_s1     <= '1;
      key_s2     <= '1;
      sw_s1      <= '0;
      sw_s2      <= '0;
      sw_prev    <= '0;
      key_stable <= '0;
      sw_stable  <= '0;
      sw_cnt     <= '0;
      edge_flags <= '0;
      ctrl_en    <= 1'b0;
      Input_IRQ  <= 1'b0;
      // NOTE: the counter array is reset too; a press held through reset must restart from zero.
      for (int i = 0; i < NUM_KEYS; i++) key_cnt[i] <= '0;
    end else begin
      key_s1     <= key_in;
      key_s2     <= key_s1;
      sw_s1      <= switch_in;
      sw_s2      <= sw_s1;
      sw_prev    <= sw_s2;
      key_stable <= key_stable_nxt;
      sw_stable  <= sw_stable_nxt;
      sw_cnt     <= sw_cnt_nxt;
      edge_flags <= edge_nxt;
      ctrl_en    <= ctrl_nxt;
      Input_IRQ  <= ctrl_nxt & (|edge_nxt);
      for (int i = 0; i < NUM_KEYS; i++) key_cnt[i] <= key_cnt_nxt[i];
    end
  end

  // Reads see register contents ahead of any write on the coming edge.
  always_comb begin
    Input_ReadData = '0;
    case (reg_sel)
      REG_SWITCH: Input_ReadData = sw_stable;
      REG_KEY:    Input_ReadData = 32'(key_stable);
      REG_EDGE:   Input_ReadData = 32'(edge_flags);
      REG_CTRL:   Input_ReadData = {31'b0, ctrl_en};
      default:    Input_ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_key_switch_input.sv
// Directed bench for key_switch_input with DEBOUNCE_CYCLES=4, NUM_KEYS=8.
module tb_key_switch_input;

  localparam int NK = 8;
  localparam logic [31:0] A_SW = 32'h0, A_KEY = 32'h4, A_EDGE = 32'h8, A_CTRL = 32'hC;

  logic          clk_in = 1'b0;
  logic          sys_rstn;
  logic [NK-1:0] key_in;
  logic [31:0]   switch_in;
  logic [31:0]   Input_Addr;
  logic [3:0]    Input_WE;
  logic [31:0]   Input_WriteData;
  logic [31:0]   Input_ReadData;
  logic          Input_IRQ;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  key_switch_input #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk_in(clk_in), .sys_rstn(sys_rstn), .key_in(key_in), .switch_in(switch_in),
    .Input_Addr(Input_Addr), .Input_WE(Input_WE), .Input_WriteData(Input_WriteData),
    .Input_ReadData(Input_ReadData), .Input_IRQ(Input_IRQ)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    Input_Addr = addr;
    #1;
    data = Input_ReadData;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    Input_Addr      = addr;
    Input_WE        = we;
    Input_WriteData = data;
    tick();
    Input_WE        = 4'h0;
    Input_WriteData = 32'h0;
  endtask

  // Ticks until the register reads exp or max cycles pass; cycles = -1 when the bound expires.
  task automatic wait_read(input logic [31:0] addr, input logic [31:0] exp, input int max,
                           output int cycles);
    logic [31:0] d;
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      rd(addr, d);
      if (d === exp) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    rd(addr, d);
    check(tag, d, exp);
  endtask

  initial begin
    sys_rstn        = 1'b0;
    key_in          = 8'hFF;
    switch_in       = 32'h0;
    Input_Addr      = 32'h0;
    Input_WE        = 4'h0;
    Input_WriteData = 32'h0;
    #2;
    check("rst_irq", {31'b0, Input_IRQ}, 32'h0);
    check_read("rst_switch", A_SW, 32'h0);
    check_read("rst_key", A_KEY, 32'h0);
    check_read("rst_edge", A_EDGE, 32'h0);
    check_read("rst_ctrl", A_CTRL, 32'h0);
    @(negedge clk_in);
    sys_rstn = 1'b1;
    repeat (20) tick();
    check_read("idle_key", A_KEY, 32'h0);
    check_read("idle_edge", A_EDGE, 32'h0);

    // Three-cycle glitch on key 3 must be filtered out.
    key_in = 8'hF7;
    repeat (3) tick();
    key_in = 8'hFF;
    repeat (10) tick();
    check_read("glitch_key", A_KEY, 32'h0);
    check_read("glitch_edge", A_EDGE, 32'h0);

    // Held press on key 3.
    key_in = 8'hF7;
    wait_read(A_KEY, 32'h8, 12, cyc);
    check("press_latency_ok", {31'b0, (cyc >= 5 && cyc <= 7)}, 32'h1);
    check_read("press_edge", A_EDGE, 32'h8);
    check("press_irq_disabled", {31'b0, Input_IRQ}, 32'h0);

    key_in = 8'hFF;
    wait_read(A_KEY, 32'h0, 12, cyc);
    check("release_latency_ok", {31'b0, (cyc >= 5 && cyc <= 7)}, 32'h1);
    check_read("release_edge_sticky", A_EDGE, 32'h8);

    // Interrupt enable and write-1-to-clear.
    wr(A_CTRL, 4'h1, 32'hFFFF_FFFF);
    check_read("ctrl_readback", A_CTRL, 32'h1);
    check("irq_set", {31'b0, Input_IRQ}, 32'h1);
    wr(A_EDGE, 4'h0, 32'h8);
    check_read("edge_we0_nochange", A_EDGE, 32'h8);
    wr(A_EDGE, 4'h2, 32'h8);
    check_read("edge_wrong_byte_nochange", A_EDGE, 32'h8);
    check("irq_still_set", {31'b0, Input_IRQ}, 32'h1);
    wr(A_EDGE, 4'h1, 32'h8);
    check_read("edge_cleared", A_EDGE, 32'h0);
    check("irq_cleared", {31'b0, Input_IRQ}, 32'h0);

    // Key 5 press debounces on the same edge as a clear of EDGE[5]: the set must win.
    key_in = 8'hDF;
    repeat (5) tick();
    check_read("collide_key_before", A_KEY, 32'h0);
    check_read("collide_edge_before", A_EDGE, 32'h0);
    wr(A_EDGE, 4'h1, 32'h20);
    check_read("collide_key", A_KEY, 32'h20);
    check_read("collide_edge", A_EDGE, 32'h20);
    check("collide_irq", {31'b0, Input_IRQ}, 32'h1);

    // Switch word debounce.
    switch_in = 32'hA5A5_0F0F;
    wait_read(A_SW, 32'hA5A5_0F0F, 12, cyc);
    check("switch_latency_ok", {31'b0, (cyc >= 5 && cyc <= 7)}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      switch_in[0] = ~switch_in[0];
      repeat (2) tick();
    end
    check_read("switch_toggle_filtered", A_SW, 32'hA5A5_0F0F);
    switch_in = 32'hA5A5_0F0F;
    repeat (8) tick();
    wr(A_SW, 4'hF, 32'h0);
    check_read("switch_ro", A_SW, 32'hA5A5_0F0F);
    wr(A_KEY, 4'hF, 32'hFFFF_FFFF);
    check_read("key_ro", A_KEY, 32'h20);

    // Asynchronous reset mid-debounce of key 2 while the interrupt is active.
    check("pre_reset_irq", {31'b0, Input_IRQ}, 32'h1);
    key_in = 8'hDB;
    repeat (3) tick();
    #1;
    sys_rstn = 1'b0;
    #1;
    check("async_rst_irq", {31'b0, Input_IRQ}, 32'h0);
    check_read("async_rst_edge", A_EDGE, 32'h0);
    check_read("async_rst_ctrl", A_CTRL, 32'h0);
    check_read("async_rst_key", A_KEY, 32'h0);
    @(negedge clk_in);
    sys_rstn = 1'b1;
    wait_read(A_KEY, 32'h24, 12, cyc);
    check("redebounce_latency_ok", {31'b0, (cyc >= 5 && cyc <= 8)}, 32'h1);
    check_read("redebounce_edge", A_EDGE, 32'h24);
    check("redebounce_irq_off", {31'b0, Input_IRQ}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
